// File: rtl/staged_mac_pkg.sv
// -----------------------------------------------------------------------------
// staged_mac_pkg
// Shared constants, types and helpers for the accumulator requantize/pack path.
//   ACC_W     : accumulator width (also packed output word width)
//   OUT_W     : requantized element width
//   PACK      : elements per output word
//   SCALE_W   : unsigned scale multiplier width
//   SHIFT_W   : right-shift amount width
//   MAX_SHIFT : largest shift honoured; larger requests are clamped
// -----------------------------------------------------------------------------
package staged_mac_pkg;

    localparam int unsigned ACC_W     = 32;
    localparam int unsigned OUT_W     = 8;
    localparam int unsigned PACK      = ACC_W / OUT_W;
    localparam int unsigned SCALE_W   = 16;
    localparam int unsigned SHIFT_W   = 6;
    localparam int unsigned MAX_SHIFT = 47;

    // Signed acc * signed {0,scale}
    localparam int unsigned PROD_W    = ACC_W + SCALE_W + 1;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [OUT_W-1:0] elem_t;
    typedef logic        [PACK-1:0]  keep_t;
    // One guard bit above the product so the rounding add cannot overflow
    typedef logic signed [PROD_W:0]  wide_t;

    function automatic elem_t sat_s8(input wide_t v);
        elem_t res;
        if (v > wide_t'(127)) begin
            res = elem_t'(127);
        end else if (v < wide_t'(-128)) begin
            res = elem_t'(-128);
        end else begin
            res = elem_t'(v);
        end
        return res;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// -----------------------------------------------------------------------------
// requant_sat
// Two-stage requantizer: S1 scales the accumulator, S2 applies the rounding
// arithmetic shift, optional ReLU, zero-point add and signed 8-bit saturation.
// Config and sideband (last/id) travel with the data; everything advances only
// while en_i is high.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   en_i               : pipeline advance enable
//   valid_i            : beat accepted this cycle
//   data_i             : signed accumulator result
//   scale_i, shift_i   : scale multiplier, right-shift amount
//   relu_i, zp_i       : ReLU enable, signed zero point
//   last_i, id_i       : packet sideband
//   valid_o, elem_o    : requantized element out of S2
//   last_o, id_o       : sideband out of S2
// -----------------------------------------------------------------------------
module requant_sat
    import staged_mac_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               valid_i,
    input  acc_t               data_i,
    input  logic [SCALE_W-1:0] scale_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               relu_i,
    input  elem_t              zp_i,
    input  logic               last_i,
    input  logic [7:0]         id_i,
    output logic               valid_o,
    output elem_t              elem_o,
    output logic               last_o,
    output logic [7:0]         id_o
);

    // S1 registers
    logic                     v1_q;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic [SHIFT_W-1:0]       shift_q, shift_d;
    logic                     relu_q;
    elem_t                    zp_q;
    logic                     last1_q;
    logic [7:0]               id1_q;

    // S2 registers
    logic                     v2_q;
    elem_t                    elem_q, elem_d;
    logic                     last2_q;
    logic [7:0]               id2_q;

    wide_t                    x, rnd, r;

    always_comb begin
        prod_d  = PROD_W'(data_i) * PROD_W'($signed({1'b0, scale_i}));
        shift_d = (shift_i > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : shift_i;
    end

    always_comb begin
        x   = wide_t'(prod_q);
        rnd = '0;
        if (shift_q != '0) begin
            rnd[shift_q - 1'b1] = 1'b1;
        end
        r = (x + rnd) >>> shift_q;
        if (relu_q && (r < 0)) begin
            r = '0;
        end
        r      = r + wide_t'(zp_q);
        elem_d = sat_s8(r);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q    <= 1'b0;
            prod_q  <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            zp_q    <= '0;
            last1_q <= 1'b0;
            id1_q   <= '0;
            v2_q    <= 1'b0;
            elem_q  <= '0;
            last2_q <= 1'b0;
            id2_q   <= '0;
        end else if (en_i) begin
            v1_q    <= valid_i;
            prod_q  <= prod_d;
            shift_q <= shift_d;
            relu_q  <= relu_i;
            zp_q    <= zp_i;
            last1_q <= last_i;
            id1_q   <= id_i;
            v2_q    <= v1_q;
            elem_q  <= elem_d;
            last2_q <= last1_q;
            id2_q   <= id1_q;
        end
    end

    assign valid_o = v2_q;
    assign elem_o  = elem_q;
    assign last_o  = last2_q;
    assign id_o    = id2_q;

endmodule

// File: rtl/mac_requant_pack.sv
// -----------------------------------------------------------------------------
// mac_requant_pack
// Requantizes a stream of signed accumulator results to signed 8-bit elements
// and packs PACK of them per output word (element k in byte k). A packet end
// (TLAST) flushes a partial word with only the used byte lanes kept.
//   ACLK, ARESET          : clock, synchronous active-high reset
//   CFG_SCALE/SHIFT/RELU/ZP : requant config, sampled with each accepted beat
//   SA_AXIS_*             : accumulator result slave stream
//   MO_AXIS_*             : packed word master stream (TKEEP, TLAST, TID)
// The whole pipeline stalls while an output word is held unaccepted, so
// SA_AXIS_TREADY is combinational from MO_AXIS_TREADY.
// -----------------------------------------------------------------------------
module mac_requant_pack #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_BITS   = 8,
    parameter int unsigned PACK       = DATA_WIDTH / OUT_BITS,
    parameter int unsigned SCALE_BITS = 16,
    parameter int unsigned SHIFT_BITS = 6
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [SCALE_BITS-1:0] CFG_SCALE,
    input  logic [SHIFT_BITS-1:0] CFG_SHIFT,
    input  logic                  CFG_RELU,
    input  logic [OUT_BITS-1:0]   CFG_ZP,
    input  logic                  SA_AXIS_TVALID,
    output logic                  SA_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0] SA_AXIS_TDATA,
    input  logic                  SA_AXIS_TLAST,
    input  logic [7:0]            SA_AXIS_TID,
    output logic                  MO_AXIS_TVALID,
    input  logic                  MO_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] MO_AXIS_TDATA,
    output logic [PACK-1:0]       MO_AXIS_TKEEP,
    output logic                  MO_AXIS_TLAST,
    output logic [7:0]            MO_AXIS_TID
);

    import staged_mac_pkg::*;

    localparam int unsigned CNT_W = $clog2(PACK);

    logic                  en;
    logic                  accept;

    logic                  v2;
    elem_t                 elem2;
    logic                  last2;
    logic [7:0]            id2;

    logic [OUT_BITS-1:0]   lanes_q [PACK];
    logic [OUT_BITS-1:0]   lanes_d [PACK];
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done;
    logic [DATA_WIDTH-1:0] word_d;
    logic [PACK-1:0]       keep_d;

    logic                  tvalid_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic [PACK-1:0]       tkeep_q;
    logic                  tlast_q;
    logic [7:0]            tid_q;

    assign en             = ~(tvalid_q & ~MO_AXIS_TREADY);
    assign SA_AXIS_TREADY = en & ~ARESET;
    assign accept         = SA_AXIS_TVALID & SA_AXIS_TREADY;

    requant_sat u_requant_sat (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .en_i    (en),
        .valid_i (accept),
        .data_i  (SA_AXIS_TDATA),
        .scale_i (CFG_SCALE),
        .shift_i (CFG_SHIFT),
        .relu_i  (CFG_RELU),
        .zp_i    (CFG_ZP),
        .last_i  (SA_AXIS_TLAST),
        .id_i    (SA_AXIS_TID),
        .valid_o (v2),
        .elem_o  (elem2),
        .last_o  (last2),
        .id_o    (id2)
    );

    // Word is assembled from the lanes including this cycle's element; lanes
    // are cleared on completion so unused upper lanes of a short word read 0.
    always_comb begin
        lanes_d = lanes_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        word_d  = '0;
        keep_d  = '0;
        if (v2) begin
            lanes_d[cnt_q] = elem2;
            done = last2 || (cnt_q == CNT_W'(PACK - 1));
            for (int unsigned k = 0; k < PACK; k++) begin
                word_d[k*OUT_BITS +: OUT_BITS] = lanes_d[k];
                keep_d[k] = (k <= 32'(cnt_q));
            end
            if (done) begin
                cnt_d = '0;
                for (int unsigned k = 0; k < PACK; k++) begin
                    lanes_d[k] = '0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt_q    <= '0;
            for (int unsigned k = 0; k < PACK; k++) begin
                lanes_q[k] <= '0;
            end
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tid_q    <= '0;
        end else if (en) begin
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
            if (done) begin
                tvalid_q <= 1'b1;
                tdata_q  <= word_d;
                tkeep_q  <= keep_d;
                tlast_q  <= last2;
                tid_q    <= id2;
            end else if (MO_AXIS_TREADY) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign MO_AXIS_TVALID = tvalid_q;
    assign MO_AXIS_TDATA  = tdata_q;
    assign MO_AXIS_TKEEP  = tkeep_q;
    assign MO_AXIS_TLAST  = tlast_q;
    assign MO_AXIS_TID    = tid_q;

endmodule
